// File: rtl/carga_rgb_if.sv
// rtl/carga_rgb_if.sv - board-side and timer-side signal bundle for the RGB loader
interface carga_rgb_if;
    logic       btn;
    logic [4:0] sw;
    logic       busy;
    logic [4:0] R;
    logic [4:0] G;
    logic [4:0] B;
    logic       enter;
    logic [2:0] sel;

    modport master (
        output btn, sw, busy,
        input  R, G, B, enter, sel
    );

    modport slave (
        input  btn, sw, busy,
        output R, G, B, enter, sel
    );
endinterface

// File: rtl/carga_rgb.sv
// rtl/carga_rgb.sv - debounced three-step R/G/B on-time loader with start pulse
module carga_rgb #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int VAL_MAX         = 15,
    parameter int SENTINEL        = 16
) (
    input  logic        clk,
    input  logic        rst,
    carga_rgb_if.slave  io
);
    localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]     VMAX     = 5'(VAL_MAX);
    localparam logic [4:0]     SENT     = 5'(SENTINEL);

    typedef enum logic [2:0] {IDLE, LOAD_R, LOAD_G, LOAD_B, FIRE} state_t;

    logic          sync1;
    logic          s;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;
    logic          press;
    logic [4:0]    val;
    state_t        state;
    logic [4:0]    r_q;
    logic [4:0]    g_q;
    logic [4:0]    b_q;
    logic          valid;

    // A new level must be seen DEBOUNCE_CYCLES times in a row before db follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= io.btn;
            s     <= sync1;
            db_q  <= db;
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = db & ~db_q;
    assign val   = (io.sw > VMAX) ? VMAX : io.sw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press && !io.busy) begin
                        valid <= 1'b0;
                        state <= LOAD_R;
                    end
                end
                LOAD_R: begin
                    if (press) begin
                        r_q   <= val;
                        state <= LOAD_G;
                    end
                end
                LOAD_G: begin
                    if (press) begin
                        g_q   <= val;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b_q   <= val;
                        valid <= 1'b1;
                        state <= FIRE;
                    end
                end
                FIRE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so sw never reaches them combinationally.
    assign io.R     = r_q;
    assign io.G     = g_q;
    assign io.B     = (valid && (state == IDLE || state == FIRE)) ? b_q : SENT;
    assign io.enter = (state == FIRE);
    assign io.sel   = (state == LOAD_R) ? 3'b100 :
                      (state == LOAD_G) ? 3'b010 :
                      (state == LOAD_B) ? 3'b001 : 3'b000;
endmodule

// File: tb/tb_carga_rgb.sv
// tb/tb_carga_rgb.sv - randomized self-checking bench for carga_rgb against a load-sequence model
module tb_carga_rgb;
    localparam int DB   = 4;
    localparam int VMAX = 15;
    localparam int SENT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    carga_rgb_if bus ();

    carga_rgb #(
        .DEBOUNCE_CYCLES(DB),
        .VAL_MAX        (VMAX),
        .SENTINEL       (SENT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int enter_seen = 0;

    // Model: phase 0 idle, 1..3 loading R/G/B, 4 start pulse cycle
    int ph;
    int mr, mg, mb;
    bit mvalid;
    int loads;

    always @(negedge clk) if (bus.enter === 1'b1) enter_seen++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ph = 0; mr = 0; mg = 0; mb = 0; mvalid = 0;
    endtask

    task automatic model_press(input int swv, input bit bz);
        int v;
        v = (swv > VMAX) ? VMAX : swv;
        case (ph)
            0: if (!bz) begin ph = 1; mvalid = 0; end
            1: begin mr = v; ph = 2; end
            2: begin mg = v; ph = 3; end
            3: begin mb = v; mvalid = 1; ph = 4; loads++; end
            default: ph = 0;
        endcase
    endtask

    task automatic check_outs(input string tag);
        int es, eb;
        es = (ph == 1) ? 4 : (ph == 2) ? 2 : (ph == 3) ? 1 : 0;
        eb = (mvalid && (ph == 0 || ph == 4)) ? mb : SENT;
        check({tag, ".R"}, int'(bus.R), mr);
        check({tag, ".G"}, int'(bus.G), mg);
        check({tag, ".B"}, int'(bus.B), eb);
        check({tag, ".sel"}, int'(bus.sel), es);
        check({tag, ".enter"}, int'(bus.enter), (ph == 4) ? 1 : 0);
    endtask

    // Clean press: btn rises just after an edge, first sampled at the next one (edge 0).
    task automatic do_press(input string tag, input int swv, input bit bz, input int hold, input int gap);
        bus.sw = 5'(swv); bus.busy = bz; bus.btn = 1'b1;
        repeat (DB + 2) tick();
        check_outs({tag, ".pre"});
        tick();
        model_press(swv, bz);
        check_outs({tag, ".edge"});
        if (ph == 4) begin
            tick();
            ph = 0;
            check_outs({tag, ".fire_end"});
        end
        repeat (hold) tick();
        check_outs({tag, ".held"});
        bus.btn  = 1'b0;
        bus.sw   = 5'($urandom_range(0, 31));
        bus.busy = 1'($urandom_range(0, 1));
        repeat (gap) tick();
        check_outs({tag, ".gap"});
        check({tag, ".enters"}, enter_seen, loads);
    endtask

    task automatic do_glitch(input string tag, input int len);
        bus.btn = 1'b1;
        repeat (len) tick();
        bus.btn = 1'b0;
        repeat (DB + 6) tick();
        check_outs(tag);
        check({tag, ".enters"}, enter_seen, loads);
    endtask

    initial begin
        loads = 0;
        model_reset();
        rst = 1'b1; bus.btn = 1'b0; bus.sw = '0; bus.busy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_outs("reset");

        // Basic load sequence
        do_press("t1_start", 9, 0, 3, DB + 5);
        do_press("t1_r", 3, 0, 2, DB + 5);
        do_press("t1_g", 7, 0, 2, DB + 5);
        do_press("t1_b", 12, 0, 2, DB + 5);

        // Clamping
        do_press("t2_start", 0, 0, 2, DB + 5);
        do_press("t2_r", 25, 0, 2, DB + 5);
        do_press("t2_g", 31, 0, 2, DB + 5);
        do_press("t2_b", 15, 0, 2, DB + 5);

        // Glitches shorter than the debounce window
        for (int l = 1; l < DB; l++) do_glitch("t3_glitch", l);

        // busy blocks a start from IDLE
        do_press("t4_busy", 5, 1, 2, DB + 5);
        do_press("t4_free", 5, 0, 2, DB + 5);

        // Reset while in LOAD_B
        do_press("t5_r", 11, 0, 2, DB + 5);
        do_press("t5_g", 6, 0, 2, DB + 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_outs("t5_rst");
        repeat (10) tick();
        check_outs("t5_after");
        check("t5_enters", enter_seen, loads);

        // Long hold gives exactly one press
        do_press("t6_long", 2, 0, 100, DB + 5);

        // Randomized presses, busy and glitches
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                do_glitch("rnd_glitch", $urandom_range(1, DB - 1));
            do_press("rnd", $urandom_range(0, 31), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 8), $urandom_range(DB + 4, DB + 12));
        end

        check("final_enters", enter_seen, loads);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
